multi_pwm_motor_ctrl: RTL
=========================

MULTI_PWM_MOTOR_CTRL -- requirements
Module: multi_pwm_motor_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent PWM channels.
REQ-002 SHALL have parameter CNT_W, default 4, width of the period counter and duty values.
REQ-003 SHALL have parameter PRESCALE, default 10, clk cycles per PWM count tick (2..2^16).
REQ-004 SHALL have parameter PERIOD, default 10, ticks per PWM period (2..2^CNT_W-1).
REQ-005 SHALL have parameter RAMP_PER, default 4, PWM periods per one-step duty ramp.
REQ-006 SHALL have clk  input  1  system clock, rising-edge.
REQ-007 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have run  input  N_CH  per-channel enable; low requests ramp-down to stop.
REQ-009 SHALL have duty_in  input  N_CH*CNT_W  per-channel target duty, channel k at bits [k*CNT_W +: CNT_W].
REQ-010 SHALL have duty_we  input  N_CH  per-channel one-cycle strobe latching duty_in into the target register.
REQ-011 SHALL have pwm  output  N_CH  registered PWM outputs.
REQ-012 SHALL have at_target  output  N_CH  high when the channel's current duty equals its effective target.
REQ-013 SHALL have active  output  N_CH  high in any state except IDLE.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and assert tick for one clk when at PRESCALE-1, free-running.
REQ-015 Shared period counter SHALL advance 0..PERIOD-1 on tick, wrapping to 0; wrap cycle = period boundary (pb).
REQ-016 Ramp counter SHALL count pb pulses 0..RAMP_PER-1; wrap generates ramp step strobe (rs).
REQ-017 Target write SHALL clamp values > PERIOD to PERIOD (100 %); write applies on the next clk.
REQ-018 Effective target SHALL equal the target register when run[k]=1, else 0.
REQ-019 Current duty SHALL change only on rs, by exactly +1 or -1 toward the effective target; never overshoot.
REQ-020 pwm[k] SHALL be registered: next value = (cur_duty[k] > period_cnt) when state != IDLE, else 0.
REQ-021 Channel FSM SHALL have states IDLE, RAMP_UP, RUN, RAMP_DOWN.
REQ-022 IDLE -> RAMP_UP when run=1 and target>0; IDLE stays while target=0.
REQ-023 RAMP_UP/RAMP_DOWN -> RUN when cur_duty reaches effective target and run=1.
REQ-024 RUN -> RAMP_UP/RAMP_DOWN when a new target above/below cur_duty is written.
REQ-025 Any state with run=0 SHALL go to RAMP_DOWN; RAMP_DOWN -> IDLE when cur_duty=0.
REQ-026 Simultaneous duty_we and rs: rs step SHALL use the old target; new target applies next cycle.
REQ-027 run re-asserted during RAMP_DOWN SHALL resume ramping from the current duty without reset to 0.
REQ-028 Duty 0 SHALL give constant-low pwm; duty PERIOD SHALL give constant-high pwm.
REQ-029 Channels SHALL be fully independent except for the shared prescaler, period and ramp counters.

Reset
REQ-030 On rst all counters, targets and cur_duty SHALL be 0, FSM IDLE, pwm=0, at_target=1, active=0.
REQ-031 rst asserted mid-operation SHALL force pwm low asynchronously; no ramp-down is performed.

Structure
REQ-032 Shared package SHALL hold the FSM state enum and default parameter constants.
REQ-033 Per-channel logic SHALL be one sub-module pwm_channel, instantiated N_CH times by generate; counters stay in top.

Verification
REQ-034 run[0]=1, duty 6 written, defaults -> cur_duty 0->6 over 24 periods, then pwm high 6 of 10 ticks (60 clk high per 100 clk).
REQ-035 In RUN at duty 6, drop run -> duty steps down to 0 every 4 periods, state IDLE, active=0, pwm constant 0.
REQ-036 Write duty 15 (>PERIOD) -> target clamps to 10; after ramp, pwm constant high.
REQ-037 Ch0 ramping to 8, ch1 written 3 simultaneously -> each ramps independently; ch1 at_target after 12 periods.
REQ-038 Assert rst while pwm high at duty 5 -> pwm=0 same cycle; after release all outputs at reset values.
REQ-039 duty_we coincident with rs in RUN -> step follows old target; new target governs from next rs.

Source files
------------

// File: rtl/multi_pwm_motor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_pwm_motor_ctrl_pkg
// Description : Shared types and default constants for the multi-channel
//               PWM motor controller (channel FSM states, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package multi_pwm_motor_ctrl_pkg;

    // Default build-time configuration of the controller
    localparam int c_DEF_N_CH     = 2;
    localparam int c_DEF_CNT_W    = 4;
    localparam int c_DEF_PRESCALE = 10;
    localparam int c_DEF_PERIOD   = 10;
    localparam int c_DEF_RAMP_PER = 4;

    // Per-channel motor state
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } pwm_state_t;

endpackage : multi_pwm_motor_ctrl_pkg
`default_nettype wire

// File: rtl/multi_pwm_motor_ctrl_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM motor channel: clamped target register, soft-start /
//               soft-stop duty ramp driven by the shared ramp strobe, state
//               machine and registered PWM output compare.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import multi_pwm_motor_ctrl_pkg::*;
#(
    parameter int CNT_W  = c_DEF_CNT_W,
    parameter int PERIOD = c_DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_we,
    input  logic             rs,
    input  logic [CNT_W-1:0] period_cnt,
    output logic             pwm,
    output logic             at_target,
    output logic             active
);

    localparam logic [CNT_W-1:0] c_PERIOD = CNT_W'(PERIOD);

    pwm_state_t       r_state;
    pwm_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_cur;
    logic [CNT_W-1:0] w_eff;
    logic [CNT_W-1:0] w_duty_clamped;
    logic             r_pwm;

    // Anything above a full period is simply 100 % duty
    assign w_duty_clamped = (duty_in > c_PERIOD) ? c_PERIOD : duty_in;

    // A stopped channel always heads for zero, whatever its stored target
    assign w_eff = run ? r_target : '0;

    // Target register; a write coincident with a ramp step only takes effect
    // after that step, since the step below reads the registered value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= '0;
        end else if (duty_we) begin
            r_target <= w_duty_clamped;
        end
    end

    // Current duty walks one count per ramp strobe toward the effective target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
        end else if (rs) begin
            if (r_cur < w_eff) begin
                r_cur <= r_cur + 1'b1;
            end else if (r_cur > w_eff) begin
                r_cur <= r_cur - 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; outside IDLE the state just tracks where the duty is
    // heading relative to the effective target
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run && (r_target != '0)) begin
                    w_state_nxt = ST_RAMP_UP;
                end
            end
            default: begin
                if ((r_cur == '0) && (w_eff == '0)) begin
                    w_state_nxt = ST_IDLE;
                end else if (!run) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else if (r_cur == w_eff) begin
                    w_state_nxt = ST_RUN;
                end else if (w_eff > r_cur) begin
                    w_state_nxt = ST_RAMP_UP;
                end else begin
                    w_state_nxt = ST_RAMP_DOWN;
                end
            end
        endcase
    end

    // Registered PWM compare; duty PERIOD exceeds every count so stays high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_state != ST_IDLE) && (r_cur > period_cnt);
        end
    end

    assign pwm       = r_pwm;
    assign at_target = (r_cur == w_eff);
    assign active    = (r_state != ST_IDLE);

endmodule : pwm_channel
`default_nettype wire

// File: rtl/multi_pwm_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_pwm_motor_ctrl
// Description : N-channel PWM motor controller. Owns the shared prescaler,
//               PWM period counter and ramp-step counter; each channel is an
//               independent pwm_channel instance.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pwm_motor_ctrl
    import multi_pwm_motor_ctrl_pkg::*;
#(
    parameter int N_CH     = c_DEF_N_CH,
    parameter int CNT_W    = c_DEF_CNT_W,
    parameter int PRESCALE = c_DEF_PRESCALE,
    parameter int PERIOD   = c_DEF_PERIOD,
    parameter int RAMP_PER = c_DEF_RAMP_PER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       run,
    input  logic [N_CH*CNT_W-1:0] duty_in,
    input  logic [N_CH-1:0]       duty_we,
    output logic [N_CH-1:0]       pwm,
    output logic [N_CH-1:0]       at_target,
    output logic [N_CH-1:0]       active
);

    localparam int c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_RAMP_W = (RAMP_PER > 1) ? $clog2(RAMP_PER) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST    = c_PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]    c_PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [c_RAMP_W-1:0] c_RAMP_LAST   = c_RAMP_W'(RAMP_PER - 1);

    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]    r_period_cnt;
    logic [c_RAMP_W-1:0] r_ramp_cnt;
    logic                w_tick;
    logic                w_pb;
    logic                w_rs;

    assign w_tick = (r_pre_cnt == c_PRE_LAST);
    assign w_pb   = w_tick && (r_period_cnt == c_PERIOD_LAST);
    assign w_rs   = w_pb && (r_ramp_cnt == c_RAMP_LAST);

    // Free-running clk prescaler producing the PWM count tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Shared PWM period counter, one count per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_tick) begin
            if (r_period_cnt == c_PERIOD_LAST) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
        end
    end

    // Counts period boundaries; its wrap is the duty ramp step strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp_cnt <= '0;
        end else if (w_pb) begin
            if (r_ramp_cnt == c_RAMP_LAST) begin
                r_ramp_cnt <= '0;
            end else begin
                r_ramp_cnt <= r_ramp_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_channel #(
            .CNT_W  (CNT_W),
            .PERIOD (PERIOD)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .run        (run[k]),
            .duty_in    (duty_in[k*CNT_W +: CNT_W]),
            .duty_we    (duty_we[k]),
            .rs         (w_rs),
            .period_cnt (r_period_cnt),
            .pwm        (pwm[k]),
            .at_target  (at_target[k]),
            .active     (active[k])
        );
    end

endmodule : multi_pwm_motor_ctrl
`default_nettype wire
